// File: rtl/mdu_ctrl.sv
// M-extension execute-stage controller: 2-stage multiplier, iterative-divider sequencing,
// one-entry last-division result cache and flush draining of the uninterruptible divider.
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        div_start,
  output logic        div_is_unsigned,
  output logic        div_is_rem,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic        div_done,
  input  logic [31:0] div_result
);

  // state     | meaning
  // IDLE      | waiting for an op; cache hits answered here
  // MUL_P     | operands latched, product being registered
  // MUL_O     | product available, result strobe
  // DIV_ISSUE | div_start pulse to the divider
  // DIV_WAIT  | waiting for div_done, result strobe on done
  // DRAIN     | flushed division still running in the divider
  typedef enum logic [2:0] {IDLE, MUL_P, MUL_O, DIV_ISSUE, DIV_WAIT, DRAIN} state_t;

  state_t             state;
  logic [2:0]         op_f3;
  logic [32:0]        op_a;
  logic [32:0]        op_b;
  logic signed [65:0] prod;
  logic signed [65:0] mul_a;
  logic signed [65:0] mul_b;
  logic               outstanding;

  logic               cache_valid;
  logic [2:0]         cache_f3;
  logic [31:0]        cache_rs1;
  logic [31:0]        cache_rs2;
  logic [31:0]        cache_res;

  logic               cache_hit;
  logic               a_signed;
  logic               b_signed;
  logic               unused_sig;

  assign cache_hit = op_valid && funct3[2] && cache_valid &&
                     ({cache_f3, cache_rs1, cache_rs2} == {funct3, rs1_val, rs2_val});

  // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed.
  assign a_signed = (funct3 != 3'b011);
  assign b_signed = !funct3[1];

  assign mul_a = {{33{op_a[32]}}, op_a};
  assign mul_b = {{33{op_b[32]}}, op_b};

  assign div_is_unsigned = op_f3[0];
  assign div_is_rem      = op_f3[1];
  assign div_dividend    = op_a[31:0];
  assign div_divisor     = op_b[31:0];

  assign unused_sig = ^{div_busy, prod[65:64], outstanding};

  always_comb begin
    result_valid = 1'b0;
    result       = '0;
    case (state)
      IDLE: begin
        if (cache_hit && !flush) begin
          result_valid = 1'b1;
          result       = cache_res;
        end
      end
      MUL_O: begin
        if (!flush) begin
          result_valid = 1'b1;
          result       = (op_f3 == 3'b000) ? prod[31:0] : prod[63:32];
        end
      end
      DIV_WAIT: begin
        if (div_done && !flush) begin
          result_valid = 1'b1;
          result       = div_result;
        end
      end
      default: ;
    endcase
  end

  assign stall = (state == DRAIN) ? op_valid : (op_valid && !result_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_f3       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      prod        <= '0;
      outstanding <= 1'b0;
      div_start   <= 1'b0;
      cache_valid <= 1'b0;
      cache_f3    <= '0;
      cache_rs1   <= '0;
      cache_rs2   <= '0;
      cache_res   <= '0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (!funct3[2]) begin
              op_f3 <= funct3;
              op_a  <= {a_signed & rs1_val[31], rs1_val};
              op_b  <= {b_signed & rs2_val[31], rs2_val};
              state <= MUL_P;
            end else if (!cache_hit) begin
              op_f3     <= funct3;
              op_a      <= {1'b0, rs1_val};
              op_b      <= {1'b0, rs2_val};
              div_start <= 1'b1;
              state     <= DIV_ISSUE;
            end
          end
        end
        MUL_P: begin
          prod  <= mul_a * mul_b;
          state <= flush ? IDLE : MUL_O;
        end
        MUL_O: state <= IDLE;
        DIV_ISSUE: begin
          outstanding <= 1'b1;
          state       <= flush ? DRAIN : DIV_WAIT;
        end
        DIV_WAIT: begin
          if (div_done) begin
            outstanding <= 1'b0;
            state       <= IDLE;
            // A flushed result must never be replayed from the cache.
            if (!flush) begin
              cache_valid <= 1'b1;
              cache_f3    <= op_f3;
              cache_rs1   <= op_a[31:0];
              cache_rs2   <= op_b[31:0];
              cache_res   <= div_result;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (div_done) begin
            outstanding <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized scoreboard bench for mdu_ctrl with a behavioural divider and an
// arithmetic reference model of the RISC-V M-extension.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        div_start;
  logic        div_is_unsigned;
  logic        div_is_rem;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_result;

  mdu_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush), .stall(stall),
    .result(result), .result_valid(result_valid), .div_start(div_start),
    .div_is_unsigned(div_is_unsigned), .div_is_rem(div_is_rem),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_done(div_done), .div_result(div_result)
  );

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          div_lat = 1;
  int          n_starts = 0;
  int          exp_starts = 0;

  bit          mc_valid = 0;
  logic [2:0]  mc_f3;
  logic [31:0] mc_a;
  logic [31:0] mc_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Behavioural iterative divider: done div_lat cycles after the start cycle.
  logic        dv_busy, dv_done;
  logic [31:0] dv_res;
  int          dv_cnt;

  assign div_busy   = dv_busy;
  assign div_done   = dv_done;
  assign div_result = dv_done ? dv_res : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (rst) begin
      dv_busy <= 1'b0;
      dv_done <= 1'b0;
      dv_cnt  <= 0;
      dv_res  <= '0;
    end else begin
      if (dv_done) begin
        dv_done <= 1'b0;
        dv_busy <= 1'b0;
      end else if (dv_busy) begin
        if (dv_cnt == 1) dv_done <= 1'b1;
        else dv_cnt <= dv_cnt - 1;
      end
      if (div_start) begin
        n_starts++;
        chk("start_while_busy", {31'b0, dv_busy}, 32'h0);
        dv_busy <= 1'b1;
        dv_res  <= ref_m({1'b1, div_is_rem, div_is_unsigned}, div_dividend, div_divisor);
        if (div_lat == 1) dv_done <= 1'b1;
        else dv_cnt <= div_lat - 1;
      end
    end
  end

  // Monitor: pops an expectation for every result strobe.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (result_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h with nothing pending (cycle %0d)", result, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("latency", cyc, e.at);
        end
      end else begin
        chk("result_idle", result, 32'h0);
      end
    end
  end

  function automatic bit model_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && mc_valid && mc_f3 == f3 && mc_a == a && mc_b == b;
  endfunction

  // Issue one op that completes; pre = cycles the controller is still draining.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int pre, input logic [31:0] exp);
    int lat, t0;
    bit hit;
    hit = model_hit(f3, a, b);
    if (!f3[2]) lat = pre + 2;
    else if (hit) lat = pre;
    else lat = pre + 1 + div_lat;
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
    t0 = cyc;
    sb_q.push_back('{res: exp, at: t0 + lat});
    if (f3[2] && !hit) begin
      exp_starts++;
      mc_valid = 1; mc_f3 = f3; mc_a = a; mc_b = b;
    end
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      chk("stall", {31'b0, stall}, (i == lat) ? 32'h0 : 32'h1);
    end
    chk("div_starts", n_starts, exp_starts);
  endtask

  // Issue one op and kill it; returns drain cycles the following op must wait.
  task automatic flush_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int fsel, output int pre);
    int fat;
    bit hit;
    hit = model_hit(f3, a, b);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
    if (!f3[2]) begin
      fat = 1 + fsel % 2; pre = 0;
    end else if (hit) begin
      fat = 0; pre = 0;
    end else begin
      fat = 1 + fsel % div_lat; pre = div_lat + 1 - fat; exp_starts++;
    end
    for (int i = 0; i <= fat; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == fat) flush = 1'b1;
      @(negedge clk);
      chk("stall_flush", {31'b0, stall}, 32'h1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      funct3 = 3'($urandom_range(0, 7)); rs1_val = $urandom; rs2_val = $urandom;
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: v = 32'h7FFFFFFF;
      5: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin : stim
    int          pre;
    logic [2:0]  f3;
    logic [31:0] a, b;

    rst = 1'b1; op_valid = 1'b1; funct3 = 3'd4; rs1_val = 32'd9; rs2_val = 32'd3; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_follows", {31'b0, stall}, 32'h1);
    chk("rst_result_valid", {31'b0, result_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_div_start", {31'b0, div_start}, 32'h0);
    chk("rst_dividend", div_dividend, 32'h0);
    chk("rst_divisor", div_divisor, 32'h0);
    op_valid = 1'b0;
    #1;
    chk("rst_stall_low", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    div_lat = 1;
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 0, 32'hFFFFFFEB);
    do_op(3'd1, 32'h80000000, 32'h80000000, 0, 32'h40000000);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE);
    div_lat = 3;
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF);
    div_lat = 1;
    do_op(3'd5, 32'd5, 32'd0, 0, 32'hFFFFFFFF);
    idle(2);

    div_lat = 5;
    flush_op(3'd4, 32'd100, 32'd7, 1, pre);
    do_op(3'd0, 32'd3, 32'd5, pre, 32'd15);
    do_op(3'd5, 32'd5, 32'd0, 0, 32'hFFFFFFFF);
    do_op(3'd4, 32'd100, 32'd7, 0, 32'd14);

    // Reset in the middle of a division: no drain, cache cleared.
    div_lat = 6;
    @(posedge clk); #1;
    op_valid = 1'b1; funct3 = 3'd4; rs1_val = 32'd1234; rs2_val = 32'd5;
    exp_starts++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_result_valid", {31'b0, result_valid}, 32'h0);
    chk("midrst_div_start", {31'b0, div_start}, 32'h0);
    chk("midrst_dividend", div_dividend, 32'h0);
    chk("midrst_stall", {31'b0, stall}, 32'h0);
    mc_valid = 0;
    div_lat = 2;
    do_op(3'd4, 32'd100, 32'd7, 0, 32'd14);

    pre = 0;
    for (int n = 0; n < 220; n++) begin
      if (pre == 0) div_lat = $urandom_range(1, 6);
      if ($urandom_range(0, 99) < 20 && mc_valid) begin
        f3 = mc_f3; a = mc_a; b = mc_b;
      end else begin
        f3 = 3'($urandom_range(0, 7)); a = rnd_opnd(); b = rnd_opnd();
      end
      if (pre == 0 && $urandom_range(0, 9) == 0) begin
        flush_op(f3, a, b, $urandom_range(0, 7), pre);
      end else begin
        do_op(f3, a, b, pre, ref_m(f3, a, b));
        pre = 0;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end

    idle(8);
    chk("scoreboard_empty", sb_q.size(), 32'h0);
    chk("div_starts_total", n_starts, exp_starts);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

M-extension execute-stage controller sitting between the EX stage and the iterative divider. Decodes the funct3 of an M-extension instruction and launches the divider with registered operands, or runs an internal 2-stage multiplier. Generates the EX stall and returns a single-cycle result strobe. A one-entry last-division cache returns repeated divisions with zero latency, and flush handling drains an uninterruptible divider.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  EX holds an M-ext instruction; held high with stable operands until result_valid or flush
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val, rs2_val  in  32  operands
- flush  in  1  kill in-flight op (branch/trap)
- stall  out  1  hold EX
- result  out  32  result; 0 when result_valid low
- result_valid  out  1  one-cycle strobe; EX advances on next edge
- div_start  out  1  registered one-cycle start pulse to divider
- div_is_unsigned, div_is_rem  out  1  funct3[0], funct3[1] of latched op
- div_dividend, div_divisor  out  32  latched operands, stable from div_start until div_done
- div_busy, div_done  in  1  divider status
- div_result  in  32  divider result, valid while div_done

## Operation
- States: IDLE, MUL_P, MUL_O, DIV_ISSUE, DIV_WAIT, DRAIN.
- IDLE, op_valid, funct3[2]=0: latch 33-bit extended operands (rs1 sign-ext for MUL/MULH/MULHSU, rs2 sign-ext for MUL/MULH only; else zero-ext) -> MUL_P.
- MUL_P: register 66-bit signed product -> MUL_O.
- MUL_O: result_valid=1; result = product[31:0] for MUL, product[63:32] otherwise -> IDLE.
- IDLE, op_valid, funct3[2]=1, cache hit: result_valid=1 same cycle, result = cached value, no divider activity, stay IDLE.
- Cache hit: cache_valid and stored {funct3, rs1, rs2} equal current inputs (all 67 bits).
- IDLE, div op, miss: latch operands and funct3 -> DIV_ISSUE.
- DIV_ISSUE: div_start=1; set outstanding -> DIV_WAIT.
- DIV_WAIT: on div_done, result_valid=1, result=div_result; load cache {funct3, operands, div_result}, cache_valid=1; clear outstanding -> IDLE.
- Divider handles div-by-zero and INT_MIN/-1 itself; no special-casing here.
- stall = op_valid && !result_valid in all states except DRAIN; stall = op_valid in DRAIN.
- flush in MUL_P/MUL_O: -> IDLE, result_valid suppressed.
- flush in DIV_ISSUE: div_start still issued that cycle -> DRAIN.
- flush in DIV_WAIT: -> DRAIN unless div_done that same cycle with outstanding clear -> IDLE; result suppressed either way.
- DRAIN: ignore op_valid; on div_done clear outstanding -> IDLE. Discarded result never loads cache.
- flush in IDLE: no effect; an IDLE cache hit coincident with flush gets result_valid suppressed.
- flush has priority over result_valid in every state.

## Timing
- Reset: state IDLE, cache_valid=0, outstanding=0, div_start=0, result_valid=0, result=0, latched operands 0. stall follows op_valid combinationally.
- rst mid-operation: immediate return to IDLE. Divider is reset by the same rst, so no drain.
- MUL latency: accept at cycle 0, result_valid at cycle 2; stall high cycles 0-1, low at cycle 2.
- DIV miss: accept at cycle 0, div_start at cycle 1, result_valid in the div_done cycle. Fastest case (special case): done at cycle 2.
- DIV hit: result_valid at cycle 0, stall never asserted.
- Back-to-back: a new op may be accepted in IDLE the cycle after result_valid.
- div_start is never asserted while outstanding=1.

## Test plan
- MUL 7 x 0xFFFFFFFD -> result_valid at cycle 2, result 0xFFFFFFEB, stall high exactly 2 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> one div_start, result 0xFFFFFFFD. Then REM on the same operands -> cache miss, new div_start, result 0xFFFFFFFF.
- Repeat REM 0xFFFFFFF9 / 2 -> result_valid same cycle, stall 0, no div_start.
- DIVU 5 / 0 -> 0xFFFFFFFF, result_valid 2 cycles after accept.
- DIV 100 / 7 flushed mid-DIV_WAIT, followed by MUL -> MUL stalled until div_done, no result_valid for DIV, cache unchanged, MUL result 2 cycles after drain exit.
